// File: rtl/fpga_cfg_loader_if.sv
// Config-word stream into the loader plus the per-column shift/commit strobes it drives into the
// CLB tile array.
interface fpga_cfg_loader_if #(
  parameter int unsigned NUM_COLS = 2,
  parameter int unsigned WORD_W   = 32
);
  logic [WORD_W-1:0]   in_data;
  logic                in_valid;
  logic                in_ready;
  logic [NUM_COLS-1:0] shift_enable;
  logic [NUM_COLS-1:0] shift_in_hard;
  logic [NUM_COLS-1:0] set_hard;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  shift_enable,
    input  shift_in_hard,
    input  set_hard
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output shift_enable,
    output shift_in_hard,
    output set_hard
  );
endinterface

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: serializes config words LSB-first into per-column hard shift chains (column 0
// first, each column starting on a fresh word) and then commits all columns with one set_hard.
module fpga_cfg_loader #(
  parameter int unsigned NUM_ROWS      = 2,
  parameter int unsigned NUM_COLS      = 2,
  parameter int unsigned TILE_CFG_BITS = 40,
  parameter int unsigned WORD_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  fpga_cfg_loader_if.slave cfg,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  localparam int unsigned COL_BITS = NUM_ROWS * TILE_CFG_BITS;
  localparam int unsigned CBW      = $clog2(COL_BITS + 1);
  localparam int unsigned WBW      = $clog2(WORD_W);
  localparam int unsigned CLW      = $clog2(NUM_COLS + 1);

  localparam logic [CBW-1:0] LastColBit  = CBW'(COL_BITS - 1);
  localparam logic [WBW-1:0] LastWordBit = WBW'(WORD_W - 1);
  localparam logic [CLW-1:0] LastCol     = CLW'(NUM_COLS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StCommit, StDone} state_e;

  state_e              st_q, st_d;
  logic [CLW-1:0]      col_q, col_d;
  logic [CBW-1:0]      col_bits_q, col_bits_d;
  logic [WBW-1:0]      wbit_q, wbit_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [NUM_COLS-1:0] shift_en_q, shift_en_d;
  logic [NUM_COLS-1:0] shift_in_q, shift_in_d;
  logic [NUM_COLS-1:0] set_hard_q, set_hard_d;
  logic                busy_d, done_d, aborted_d;
  logic                accept;

  // Abort must block a same-cycle handshake, so in_ready is the only combinational output.
  assign cfg.in_ready = (st_q == StFetch) && !abort;
  assign accept       = cfg.in_ready && cfg.in_valid;

  always_comb begin
    st_d       = st_q;
    col_d      = col_q;
    col_bits_d = col_bits_q;
    wbit_d     = wbit_q;
    word_d     = word_q;
    aborted_d  = 1'b0;

    if (abort && (st_q != StIdle)) begin
      st_d       = StIdle;
      col_d      = '0;
      col_bits_d = '0;
      wbit_d     = '0;
      aborted_d  = 1'b1;
    end else begin
      unique case (st_q)
        StIdle: begin
          if (start) begin
            st_d       = StFetch;
            col_d      = '0;
            col_bits_d = '0;
          end
        end
        StFetch: begin
          if (accept) begin
            word_d = cfg.in_data;
            wbit_d = '0;
            st_d   = StShift;
          end
        end
        StShift: begin
          wbit_d     = wbit_q + 1'b1;
          col_bits_d = col_bits_q + 1'b1;
          if (col_bits_q == LastColBit) begin
            // Column full: drop any padding left in the word, next column starts on a new word.
            col_bits_d = '0;
            wbit_d     = '0;
            col_d      = col_q + 1'b1;
            st_d       = (col_q == LastCol) ? StCommit : StFetch;
          end else if (wbit_q == LastWordBit) begin
            st_d = StFetch;
          end
        end
        StCommit: st_d = StDone;
        StDone:   st_d = StIdle;
        default:  st_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state.
  always_comb begin
    shift_en_d = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      shift_en_d[c] = (st_d == StShift) && (col_d == CLW'(c));
    end
    shift_in_d = shift_en_d & {NUM_COLS{word_d[wbit_d]}};
    set_hard_d = {NUM_COLS{st_d == StCommit}};
    busy_d     = (st_d != StIdle);
    done_d     = (st_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= StIdle;
      col_q      <= '0;
      col_bits_q <= '0;
      wbit_q     <= '0;
      word_q     <= '0;
      shift_en_q <= '0;
      shift_in_q <= '0;
      set_hard_q <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      st_q       <= st_d;
      col_q      <= col_d;
      col_bits_q <= col_bits_d;
      wbit_q     <= wbit_d;
      word_q     <= word_d;
      shift_en_q <= shift_en_d;
      shift_in_q <= shift_in_d;
      set_hard_q <= set_hard_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
    end
  end

  assign cfg.shift_enable  = shift_en_q;
  assign cfg.shift_in_hard = shift_in_q;
  assign cfg.set_hard      = set_hard_q;
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: expected serial bits are queued per column as words are
// offered and popped as shift strobes appear.
module tb_fpga_cfg_loader;
  localparam int NC = 2;
  localparam int WW = 32;
  localparam int CB = 80;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic busy, done, aborted;

  fpga_cfg_loader_if #(.NUM_COLS(NC), .WORD_W(WW)) ifc ();

  fpga_cfg_loader #(
    .NUM_ROWS(2),
    .NUM_COLS(NC),
    .TILE_CFG_BITS(40),
    .WORD_W(WW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .cfg(ifc),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int strobe_cnt [NC];
  int commit_cnt, done_cnt, aborted_cnt;
  bit exp0 [$];
  bit exp1 [$];
  logic [NC-1:0] prev_se = '0;
  logic [NC-1:0] prev_sh = '0;
  logic [31:0] words [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input int c, input int idx);
    for (int j = 0; j < WW; j++) begin
      if (idx * WW + j < CB) begin
        if (c == 0) exp0.push_back(w[j]);
        else exp1.push_back(w[j]);
      end
    end
  endtask

  task automatic pop_exp(input int c, output logic e, output bit ok);
    ok = 1'b1;
    e  = 1'b0;
    if (c == 0) begin
      if (exp0.size() == 0) ok = 1'b0;
      else e = exp0.pop_front();
    end else begin
      if (exp1.size() == 0) ok = 1'b0;
      else e = exp1.pop_front();
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NC; c++) strobe_cnt[c] = 0;
    commit_cnt  = 0;
    done_cnt    = 0;
    aborted_cnt = 0;
    exp0.delete();
    exp1.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_shift_enable"}, ifc.shift_enable, 0);
    chk({tag, "_shift_in_hard"}, ifc.shift_in_hard, 0);
    chk({tag, "_set_hard"}, ifc.set_hard, 0);
    chk({tag, "_in_ready"}, ifc.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_aborted"}, aborted, 0);
  endtask

  // Offer one word (optionally after sitting in FETCH for `stall` cycles) and wait for acceptance.
  task automatic send_word(input logic [31:0] w, input int c, input int idx, input int stall);
    int n;
    logic rdy;
    if (stall > 0) begin
      n = 0;
      while (ifc.in_ready !== 1'b1 && n < 500) begin
        step();
        n++;
      end
      chk("stall_fetch_reached", ifc.in_ready, 1);
      repeat (stall) begin
        chk("stall_no_shift", ifc.shift_enable, 0);
        step();
      end
    end
    push_word(w, c, idx);
    ifc.in_data  = w;
    ifc.in_valid = 1'b1;
    rdy = 1'b0;
    n = 0;
    while (n < 500) begin
      rdy = ifc.in_ready;
      step();
      n++;
      if (rdy === 1'b1) break;
    end
    ifc.in_valid = 1'b0;
    chk($sformatf("word%0d_col%0d_accepted", idx, c), rdy, 1);
  endtask

  task automatic run_load(input int stall_at, input bit start_mid);
    int n;
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < 6; k++) begin
      send_word(words[k], k / 3, k % 3, (k == stall_at) ? 5 : 0);
      if (start_mid && k == 0) pulse_start();
    end
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("done_seen", done, 1);
    step();
    chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic chk_full_load(input string tag);
    chk({tag, "_col0_strobes"}, strobe_cnt[0], CB);
    chk({tag, "_col1_strobes"}, strobe_cnt[1], CB);
    chk({tag, "_commits"}, commit_cnt, 1);
    chk({tag, "_dones"}, done_cnt, 1);
    chk({tag, "_no_abort"}, aborted_cnt, 0);
    chk({tag, "_exp_left"}, exp0.size() + exp1.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    logic e;
    bit ok;
    if (ifc.shift_enable !== '0) begin
      chk("se_onehot", $onehot(ifc.shift_enable), 1);
      chk("se_with_set_hard", ifc.set_hard, 0);
      chk("sih_unselected", ifc.shift_in_hard & ~ifc.shift_enable, 0);
      for (int c = 0; c < NC; c++) begin
        if (ifc.shift_enable[c]) begin
          strobe_cnt[c]++;
          pop_exp(c, e, ok);
          chk($sformatf("col%0d_shift_expected", c), ok, 1);
          if (ok) chk($sformatf("col%0d_bit%0d", c, strobe_cnt[c] - 1), ifc.shift_in_hard[c], e);
        end
      end
    end
    if (ifc.set_hard !== '0) begin
      commit_cnt++;
      chk("set_hard_all", ifc.set_hard, 2'b11);
      chk("commit_after_last_shift", prev_se, 2'b10);
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_after_commit", prev_sh, 2'b11);
    end
    if (aborted === 1'b1) aborted_cnt++;
    prev_se = ifc.shift_enable;
    prev_sh = ifc.set_hard;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int n;
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    clear_counts();
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Valid data offered while idle must not be taken.
    words = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_0000,
              32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'hCAFE_1234};
    ifc.in_data  = words[0];
    ifc.in_valid = 1'b1;
    repeat (3) begin
      chk("idle_in_ready", ifc.in_ready, 0);
      step();
    end
    ifc.in_valid = 1'b0;

    // Load A: padding word, start pulsed mid-shift.
    clear_counts();
    run_load(-1, 1'b1);
    chk_full_load("loadA");

    // Load B: 5-cycle stall before word 3.
    clear_counts();
    words = '{32'hA5A5_5A5A, 32'h0000_0001, 32'h8000_FFFF,
              32'h1357_9BDF, 32'h2468_ACE0, 32'h7FFF_8001};
    run_load(3, 1'b0);
    chk_full_load("loadB");

    // Abort after 50 col0 shifts.
    clear_counts();
    words = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_0000,
              32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'hCAFE_1234};
    pulse_start();
    send_word(words[0], 0, 0, 0);
    send_word(words[1], 0, 1, 0);
    n = 0;
    while (strobe_cnt[0] != 49 && n < 200) begin
      step();
      n++;
    end
    chk("abort_point_reached", strobe_cnt[0], 49);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_busy", busy, 0);
    chk("abort_shift_enable", ifc.shift_enable, 0);
    step();
    chk("abort_pulse_one_cycle", aborted, 0);
    chk("abort_col0_strobes", strobe_cnt[0], 50);
    chk("abort_no_commit", commit_cnt, 0);
    chk("abort_count", aborted_cnt, 1);

    // Abort in FETCH with a word offered: handshake must be blocked.
    clear_counts();
    pulse_start();
    chk("fetch_in_ready", ifc.in_ready, 1);
    ifc.in_data  = 32'h5555_AAAA;
    ifc.in_valid = 1'b1;
    abort        = 1'b1;
    #1;
    chk("abort_blocks_in_ready", ifc.in_ready, 0);
    step();
    abort        = 1'b0;
    ifc.in_valid = 1'b0;
    chk("fetch_abort_pulse", aborted, 1);
    chk("fetch_abort_busy", busy, 0);
    step();
    chk("fetch_abort_no_shift", strobe_cnt[0] + strobe_cnt[1], 0);

    // Fresh load after abort restarts at col0 bit 0.
    clear_counts();
    run_load(-1, 1'b0);
    chk_full_load("reload");

    // Reset in the middle of column 1.
    clear_counts();
    pulse_start();
    for (int k = 0; k < 4; k++) send_word(words[k], k / 3, k % 3, 0);
    n = 0;
    while (strobe_cnt[1] < 10 && n < 200) begin
      step();
      n++;
    end
    chk("rst_point_reached", strobe_cnt[1] >= 10, 1);
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    rst = 1'b0;
    repeat (3) step();
    chk("midrst_no_commit", commit_cnt, 0);
    chk("midrst_no_aborted", aborted_cnt, 0);
    chk("midrst_idle", busy, 0);
    clear_counts();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
